// File: rtl/dht11_receiver.sv
// rtl/dht11_receiver.sv - DHT11 40-bit frame receiver with checksum verification
//
// Purpose: arms on a rising edge of start, times the high phase of each of the
// 40 data bits on the (synchronised) sensor line, checks the 8-bit checksum and
// publishes the humidity/temperature bytes. The line is only sampled, never driven.
//
// Ports:
//   clk          system clock (1 MHz, 1 cycle = 1 us)
//   rst          synchronous active-high reset
//   start        arm request from the start-sequence block (rising edge arms)
//   dht_in       raw DHT11 data line, asynchronous to clk
//   hum_int      humidity integer byte
//   hum_dec      humidity decimal byte
//   temp_int     temperature integer byte
//   temp_dec     temperature decimal byte
//   data_valid   1-cycle pulse: checksum-correct frame latched
//   checksum_err 1-cycle pulse: frame received with checksum mismatch
//   timeout_err  1-cycle pulse: capture aborted because a phase ran too long
//   busy         high from arm until frame end or abort

module dht11_receiver #(
    parameter int BIT_THRESHOLD = 40,
    parameter int TIMEOUT       = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dht_in,
    output logic [7:0] hum_int,
    output logic [7:0] hum_dec,
    output logic [7:0] temp_int,
    output logic [7:0] temp_dec,
    output logic       data_valid,
    output logic       checksum_err,
    output logic       timeout_err,
    output logic       busy
);

    localparam logic [9:0] THR_CNT = 10'(BIT_THRESHOLD);
    localparam logic [9:0] TO_CNT  = 10'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOW,
        MEAS_LOW,
        MEAS_HIGH,
        CHECK
    } state_t;

    state_t      state, state_nx;
    logic [9:0]  cnt, cnt_nx;
    logic [5:0]  bit_cnt, bit_cnt_nx;
    logic [39:0] shreg, shreg_nx;
    logic [7:0]  hum_int_nx, hum_dec_nx, temp_int_nx, temp_dec_nx;
    logic        data_valid_nx, checksum_err_nx, timeout_err_nx;

    logic        sync1, dht_s, start_d;
    logic        start_edge;
    logic        timed_out;
    logic [9:0]  cnt_inc;
    logic [7:0]  sum;

    assign start_edge = start & ~start_d;
    assign timed_out  = (cnt >= TO_CNT);
    // Saturating increment: the counter must never wrap back under TIMEOUT.
    assign cnt_inc    = (cnt == 10'h3FF) ? cnt : cnt + 10'd1;
    assign sum        = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
    assign busy       = (state != IDLE);

    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        bit_cnt_nx      = bit_cnt;
        shreg_nx        = shreg;
        hum_int_nx      = hum_int;
        hum_dec_nx      = hum_dec;
        temp_int_nx     = temp_int;
        temp_dec_nx     = temp_dec;
        data_valid_nx   = 1'b0;
        checksum_err_nx = 1'b0;
        timeout_err_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nx   = WAIT_LOW;
                    bit_cnt_nx = 6'd0;
                    cnt_nx     = 10'd0;
                end
            end
            WAIT_LOW: begin
                if (timed_out) begin
                    timeout_err_nx = 1'b1;
                    state_nx       = IDLE;
                end else if (!dht_s) begin
                    state_nx = MEAS_LOW;
                    cnt_nx   = 10'd0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            MEAS_LOW: begin
                if (timed_out) begin
                    timeout_err_nx = 1'b1;
                    state_nx       = IDLE;
                end else if (dht_s) begin
                    // The rising-edge cycle is already high, so the high-phase
                    // count starts at 1 and ends equal to the high length.
                    state_nx = MEAS_HIGH;
                    cnt_nx   = 10'd1;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            MEAS_HIGH: begin
                if (timed_out) begin
                    timeout_err_nx = 1'b1;
                    state_nx       = IDLE;
                end else if (!dht_s) begin
                    shreg_nx   = {shreg[38:0], (cnt > THR_CNT)};
                    bit_cnt_nx = bit_cnt + 6'd1;
                    if (bit_cnt == 6'd39) begin
                        state_nx = CHECK;
                    end else begin
                        state_nx = MEAS_LOW;
                        cnt_nx   = 10'd0;
                    end
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            CHECK: begin
                if (sum == shreg[7:0]) begin
                    hum_int_nx    = shreg[39:32];
                    hum_dec_nx    = shreg[31:24];
                    temp_int_nx   = shreg[23:16];
                    temp_dec_nx   = shreg[15:8];
                    data_valid_nx = 1'b1;
                end else begin
                    checksum_err_nx = 1'b1;
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 10'd0;
            bit_cnt      <= 6'd0;
            shreg        <= 40'd0;
            hum_int      <= 8'h00;
            hum_dec      <= 8'h00;
            temp_int     <= 8'h00;
            temp_dec     <= 8'h00;
            data_valid   <= 1'b0;
            checksum_err <= 1'b0;
            timeout_err  <= 1'b0;
            sync1        <= 1'b1;
            dht_s        <= 1'b1;
            start_d      <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            bit_cnt      <= bit_cnt_nx;
            shreg        <= shreg_nx;
            hum_int      <= hum_int_nx;
            hum_dec      <= hum_dec_nx;
            temp_int     <= temp_int_nx;
            temp_dec     <= temp_dec_nx;
            data_valid   <= data_valid_nx;
            checksum_err <= checksum_err_nx;
            timeout_err  <= timeout_err_nx;
            sync1        <= dht_in;
            dht_s        <= sync1;
            start_d      <= start;
        end
    end

endmodule
